// File: rtl/cpu_pkg.sv
// Shared definitions for the jr redirect control slice: FSM states,
// the default exception vector and the register-index width.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REDIRECT
  } jr_state_e;

  localparam logic [31:0] EXC_VEC_DEF = 32'h0000_0080;
  localparam int          REG_IDX_W   = 5;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/jr_redirect_ctrl.sv
// Turns an ID-stage jr into a one-cycle PC redirect, holding fetch while the
// rs operand is still being produced in EX/MEM; counts redirects and hold cycles.
module jr_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
  parameter int          CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 jr_i,
  input  logic [REG_IDX_W-1:0] rs_idx_i,
  input  logic [31:0]          rs_data_i,
  input  logic                 ex_regwrite_i,
  input  logic                 mem_regwrite_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic [REG_IDX_W-1:0] mem_rd_i,
  input  logic                 clr_cnt_i,
  output logic                 stall_o,
  output logic                 redirect_o,
  output logic [31:0]          target_o,
  output logic                 flush_o,
  output logic                 misalign_o,
  output logic [CNT_W-1:0]     jr_cnt_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  jr_state_e   r_state;
  jr_state_e   w_next_state;
  logic [31:0] r_target;
  logic        r_misalign;
  logic        w_hazard;
  logic        w_latch;

  // $0 is hardwired, so a pending write to it never blocks the read.
  assign w_hazard = (rs_idx_i != '0) &&
                    ((ex_regwrite_i  && (ex_rd_i  == rs_idx_i)) ||
                     (mem_regwrite_i && (mem_rd_i == rs_idx_i)));

  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    stall_o      = 1'b0;
    redirect_o   = 1'b0;
    flush_o      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        stall_o = jr_i;
        if (jr_i) begin
          if (w_hazard) begin
            w_next_state = ST_HOLD;
          end else begin
            w_latch      = 1'b1;
            w_next_state = ST_REDIRECT;
          end
        end
      end
      ST_HOLD: begin
        stall_o = 1'b1;
        if (!w_hazard) begin
          w_latch      = 1'b1;
          w_next_state = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        redirect_o   = 1'b1;
        flush_o      = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        if (is_misaligned(rs_data_i)) begin
          r_target   <= EXC_VEC;
          r_misalign <= 1'b1;
        end else begin
          r_target <= rs_data_i;
        end
      end
    end
  end

  assign target_o   = r_target;
  assign misalign_o = r_misalign;

  sat_counter #(.W(CNT_W)) u_jr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (r_state == ST_REDIRECT),
    .clr_i (clr_cnt_i),
    .cnt_o (jr_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (r_state == ST_HOLD),
    .clr_i (clr_cnt_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_jr_redirect_ctrl.sv
// Directed and randomized checks of jr_redirect_ctrl against a transaction-level model.
module tb_jr_redirect_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             jr_i = 1'b0;
  logic [4:0]       rs_idx_i = '0;
  logic [31:0]      rs_data_i = '0;
  logic             ex_regwrite_i = 1'b0;
  logic             mem_regwrite_i = 1'b0;
  logic [4:0]       ex_rd_i = '0;
  logic [4:0]       mem_rd_i = '0;
  logic             clr_cnt_i = 1'b0;
  logic             stall_o, redirect_o, flush_o, misalign_o;
  logic [31:0]      target_o;
  logic [CNT_W-1:0] jr_cnt_o, stall_cnt_o;

  int checks = 0;
  int failures = 0;

  // Model: a jr is "pending" while its operand is not yet readable;
  // "redir" marks the single cycle in which the PC is redirected.
  bit          m_pending, m_redir, m_mis;
  logic [31:0] m_target;
  int          m_jr_cnt, m_stall_cnt;

  jr_redirect_ctrl #(.EXC_VEC(32'h0000_0080), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .jr_i(jr_i), .rs_idx_i(rs_idx_i),
    .rs_data_i(rs_data_i), .ex_regwrite_i(ex_regwrite_i),
    .mem_regwrite_i(mem_regwrite_i), .ex_rd_i(ex_rd_i), .mem_rd_i(mem_rd_i),
    .clr_cnt_i(clr_cnt_i), .stall_o(stall_o), .redirect_o(redirect_o),
    .target_o(target_o), .flush_o(flush_o), .misalign_o(misalign_o),
    .jr_cnt_o(jr_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_redir = 0; m_mis = 0; m_target = '0;
    m_jr_cnt = 0; m_stall_cnt = 0;
  endtask

  task automatic check_all();
    bit exp_stall;
    exp_stall = m_pending ? 1'b1 : (m_redir ? 1'b0 : jr_i);
    chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
    chk("redirect", {31'b0, redirect_o}, {31'b0, m_redir});
    chk("flush", {31'b0, flush_o}, {31'b0, m_redir});
    chk("target", target_o, m_target);
    chk("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
    chk("jr_cnt", {28'b0, jr_cnt_o}, m_jr_cnt);
    chk("stall_cnt", {28'b0, stall_cnt_o}, m_stall_cnt);
  endtask

  task automatic model_edge();
    bit haz, was_hold, was_redir;
    haz = (rs_idx_i != 0) && ((ex_regwrite_i && ex_rd_i == rs_idx_i) ||
                              (mem_regwrite_i && mem_rd_i == rs_idx_i));
    was_hold  = m_pending;
    was_redir = m_redir;
    if (m_redir) begin
      m_redir = 0;
    end else if (m_pending || jr_i) begin
      if (haz) begin
        m_pending = 1;
      end else begin
        m_pending = 0;
        m_redir   = 1;
        if (rs_data_i % 4 != 0) begin
          m_target = 32'h0000_0080;
          m_mis    = 1;
        end else begin
          m_target = rs_data_i;
        end
      end
    end
    if (clr_cnt_i) begin
      m_jr_cnt = 0; m_stall_cnt = 0;
    end else begin
      if (was_redir && m_jr_cnt < CMAX) m_jr_cnt++;
      if (was_hold && m_stall_cnt < CMAX) m_stall_cnt++;
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    jr_i = 0; rs_idx_i = 0; rs_data_i = 0; ex_regwrite_i = 0; mem_regwrite_i = 0;
    ex_rd_i = 0; mem_rd_i = 0; clr_cnt_i = 0;
  endtask

  task automatic jr_clean(input logic [4:0] rs, input logic [31:0] data);
    idle_inputs();
    jr_i = 1; rs_idx_i = rs; rs_data_i = data;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_i = 1'b1;
    tick();

    // No hazard: stall in N, redirect/flush and target in N+1.
    clr_cnt_i = 1; tick(); clr_cnt_i = 0;
    jr_i = 1; rs_idx_i = 5'd8; rs_data_i = 32'h0040_0100;
    #1 chk("nohaz_stall_N", {31'b0, stall_o}, 32'd1);
    tick();
    idle_inputs();
    #1 chk("nohaz_redir_N1", {31'b0, redirect_o}, 32'd1);
    chk("nohaz_target", target_o, 32'h0040_0100);
    tick();
    #1 chk("nohaz_jr_cnt", {28'b0, jr_cnt_o}, 32'd1);
    tick();

    // EX hazard for two cycles: three stall cycles, redirect at N+3.
    clr_cnt_i = 1; tick(); clr_cnt_i = 0;
    jr_i = 1; rs_idx_i = 5'd8; rs_data_i = 32'h0040_0200;
    ex_rd_i = 5'd8; ex_regwrite_i = 1;
    tick(); tick();
    ex_regwrite_i = 0;
    tick();
    idle_inputs();
    #1 chk("exhaz_redir_N3", {31'b0, redirect_o}, 32'd1);
    chk("exhaz_stall_cnt", {28'b0, stall_cnt_o}, 32'd2);
    tick(); tick();

    // MEM hazard for one cycle.
    jr_i = 1; rs_idx_i = 5'd3; rs_data_i = 32'h0000_1000;
    mem_rd_i = 5'd3; mem_regwrite_i = 1;
    tick();
    mem_regwrite_i = 0;
    tick();
    idle_inputs();
    tick(); tick();

    // rs = $0 with a write to $0 in EX: no hold.
    jr_i = 1; rs_idx_i = 5'd0; rs_data_i = 32'h0000_0000;
    ex_rd_i = 5'd0; ex_regwrite_i = 1;
    tick();
    idle_inputs();
    #1 chk("r0_redir_N1", {31'b0, redirect_o}, 32'd1);
    tick(); tick();

    // Misaligned target, sticky across a later good jr.
    jr_clean(5'd9, 32'h0040_0102);
    #1 chk("mis_target", target_o, 32'h0000_0080);
    chk("mis_flag", {31'b0, misalign_o}, 32'd1);
    jr_clean(5'd9, 32'h0040_0100);
    #1 chk("mis_sticky", {31'b0, misalign_o}, 32'd1);
    chk("good_target", target_o, 32'h0040_0100);

    // Async reset while in HOLD.
    jr_i = 1; rs_idx_i = 5'd8; ex_rd_i = 5'd8; ex_regwrite_i = 1;
    tick();
    jr_i = 0;
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_redirect", {31'b0, redirect_o}, 32'd0);
    chk("rst_target", target_o, 32'd0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
    chk("rst_jr_cnt", {28'b0, jr_cnt_o}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_i = 1'b1;
    tick(); tick(); tick();

    // Clear coincident with REDIRECT.
    jr_i = 1; rs_idx_i = 5'd4; rs_data_i = 32'h0000_2000;
    tick();
    idle_inputs();
    clr_cnt_i = 1;
    tick();
    clr_cnt_i = 0;
    #1 chk("clr_wins_jr_cnt", {28'b0, jr_cnt_o}, 32'd0);
    tick();

    // Saturation: 17 redirects into a 4-bit counter.
    for (int i = 0; i < 17; i++) jr_clean(5'd5, 32'h0000_4000 + 32'(i * 4));
    #1 chk("sat_jr_cnt", {28'b0, jr_cnt_o}, 32'h0000_000F);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      jr_i           = ($urandom_range(0, 2) == 0);
      rs_idx_i       = 5'($urandom_range(0, 3));
      ex_rd_i        = 5'($urandom_range(0, 3));
      mem_rd_i       = 5'($urandom_range(0, 3));
      ex_regwrite_i  = ($urandom_range(0, 2) == 0);
      mem_regwrite_i = ($urandom_range(0, 2) == 0);
      rs_data_i      = $urandom();
      if ($urandom_range(0, 7) != 0) rs_data_i[1:0] = 2'b00;
      clr_cnt_i      = ($urandom_range(0, 60) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jr_redirect_ctrl.md
# jr_redirect_ctrl

Sequential control block that consumes the ID-stage `jr` detect flag and turns it into a PC redirect for the pipelined MIPS CPU. It holds the fetch front-end while the `rs` operand is still in flight in EX/MEM, captures the jump target once it is readable from the register file, issues a one-cycle redirect with IF/ID flush, and keeps saturating event counters for jr traffic and stall cycles. It sits between the ID-stage decode/jr detector and the PC/IF-ID pipeline registers.

## Interface
- `EXC_VEC`, 32'h0000_0080, substitute target when the jr target is not word-aligned
- `CNT_W`, 16, width of the performance counters
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-low
- `jr_i`  in  1  ID-stage instruction is `jr` (from jr detector)
- `rs_idx_i`  in  5  rs field of the ID-stage instruction
- `rs_data_i`  in  32  register-file read of rs (write-first, so WB values are visible)
- `ex_regwrite_i`, `mem_regwrite_i`  in  1 each  EX/MEM stage writes a register
- `ex_rd_i`, `mem_rd_i`  in  5 each  EX/MEM destination register
- `clr_cnt_i`  in  1  synchronous counter clear
- `stall_o`  out  1  hold PC and IF/ID, insert bubble into ID/EX
- `redirect_o`  out  1  load PC with `target_o` this cycle
- `target_o`  out  32  redirect target
- `flush_o`  out  1  flush IF/ID this cycle
- `misalign_o`  out  1  sticky misaligned-target flag
- `jr_cnt_o`  out  CNT_W  redirects issued
- `stall_cnt_o`  out  CNT_W  HOLD cycles spent

## Operation
- Hazard = `rs_idx_i != 0` and ((`ex_regwrite_i` and `ex_rd_i == rs_idx_i`) or (`mem_regwrite_i` and `mem_rd_i == rs_idx_i`)).
- States: IDLE, HOLD, REDIRECT.
- IDLE: `stall_o = jr_i` (combinational). On `jr_i`: hazard -> HOLD; else latch `rs_data_i` -> REDIRECT.
- HOLD: `stall_o = 1`; each cycle increments stall counter. Hazard clear -> latch `rs_data_i` -> REDIRECT; else stay.
- REDIRECT: `redirect_o = 1`, `flush_o = 1`, `stall_o = 0`; jr counter increments; `jr_i` ignored; -> IDLE unconditionally.
- Target latch: if latched value `[1:0] != 0`, `target_o <= EXC_VEC` and `misalign_o <= 1` (sticky until reset); else `target_o <=` latched value.
- Counters saturate at all-ones; `clr_cnt_i` clears both and wins over a same-cycle increment.

## Timing
- Reset (async, any state): state IDLE, `redirect_o`/`flush_o`/`misalign_o` 0, `target_o` 0, counters 0; `stall_o` 0 unless `jr_i` asserted (combinational path only).
- No hazard: `jr_i` in cycle N -> `stall_o` in N, `redirect_o`/`flush_o` in N+1, target fetched in N+2.
- k hazard cycles: redirect at N+1+k; `stall_o` high for N..N+k.
- `redirect_o` and `flush_o` are always exactly one-cycle pulses, never back-to-back.
- `target_o` stable from REDIRECT cycle until next latch.
- Reset during HOLD/REDIRECT: pending redirect dropped, no counter increment.

## Structure
- Shared package `cpu_pkg`: state enum (IDLE/HOLD/REDIRECT), `EXC_VEC` default, register-index width constant.
- One sub-module: `sat_counter` (width param, inc, clr, clr priority), instantiated twice.

## Test plan
- No hazard: `jr_i=1`, rs=$8, `rs_data_i=32'h0040_0100` at N -> `stall_o` at N, `redirect_o=1`, `flush_o=1`, `target_o=32'h0040_0100` at N+1, `jr_cnt_o=1`.
- EX hazard: `ex_rd_i=8`, `ex_regwrite_i=1` for 2 cycles -> `stall_o` 3 cycles, redirect at N+3, `stall_cnt_o=2`.
- rs=$0 with `ex_rd_i=0`, `ex_regwrite_i=1` -> no HOLD, redirect at N+1.
- Misaligned: `rs_data_i=32'h0040_0102` -> `target_o=32'h0000_0080`, `misalign_o=1`, stays 1 after next good jr.
- Async reset asserted in HOLD -> outputs 0 immediately, no redirect after release; `clr_cnt_i` coincident with REDIRECT -> `jr_cnt_o=0`.
- Saturation: CNT_W=4, 17 jr redirects -> `jr_cnt_o=4'hF`.
